sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_if.sv | 59 +++++
 rtl/sram_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sram_arbiter_if
// Purpose  : Bundle of the two requester ports (data / instruction) and the
//            single-port SRAM port that the arbiter multiplexes between them.
// Ports    : d_*    data port: req/addr/wea/dina in, gnt/rvalid/rdata out
//            i_*    instruction port: req/addr in, gnt/rvalid/rdata out
//            sram_* SRAM side: ena/addra/wea/dina out, douta in
// Modports : slave  - arbiter view (requests in, grants/SRAM drive out)
//            master - requester/SRAM environment view (mirror of slave)
// Revision : 1.0 - initial release
// ============================================================================
interface sram_arbiter_if #(
    parameter int LEN_ADDR = 64,
    parameter int LEN_DATA = 64
);
    // Data port
    logic                  d_req;
    logic [LEN_ADDR-1:0]   d_addr;
    logic [LEN_DATA/8-1:0] d_wea;
    logic [LEN_DATA-1:0]   d_dina;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [LEN_DATA-1:0]   d_rdata;

    // Instruction port
    logic                  i_req;
    logic [LEN_ADDR-1:0]   i_addr;
    logic                  i_gnt;
    logic                  i_rvalid;
    logic [LEN_DATA-1:0]   i_rdata;

    // SRAM port
    logic                  sram_ena;
    logic [LEN_ADDR-1:0]   sram_addra;
    logic [LEN_DATA/8-1:0] sram_wea;
    logic [LEN_DATA-1:0]   sram_dina;
    logic [LEN_DATA-1:0]   sram_douta;

    modport slave (
        input  d_req, d_addr, d_wea, d_dina,
        output d_gnt, d_rvalid, d_rdata,
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        output sram_ena, sram_addra, sram_wea, sram_dina,
        input  sram_douta
    );

    modport master (
        output d_req, d_addr, d_wea, d_dina,
        input  d_gnt, d_rvalid, d_rdata,
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        input  sram_ena, sram_addra, sram_wea, sram_dina,
        output sram_douta
    );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Two-port to single-port SRAM arbiter. Data port has default
//            priority; an instruction request denied MAX_WAIT consecutive
//            cycles is forced through. Grants are combinational in the
//            request cycle, read data returns exactly one cycle later and is
//            routed to the port recorded in a registered owner tag.
// Ports    : clk  - clock
//            rst  - synchronous active-high reset
//            bus  - sram_arbiter_if.slave (data port, instruction port, SRAM)
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int LEN_ADDR = 64,
    parameter int LEN_DATA = 64,
    parameter int MAX_WAIT = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    sram_arbiter_if.slave bus
);
    localparam int c_BE_W  = LEN_DATA / 8;
    localparam int c_CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MAX_WAIT);

    // Starvation counter and owner tag of the read in flight
    logic [c_CNT_W-1:0]  r_wait_cnt;
    logic                r_tag_valid;
    logic                r_tag_port;    // 1 = instruction port, 0 = data port
    logic [LEN_DATA-1:0] r_d_hold;
    logic [LEN_DATA-1:0] r_i_hold;

    logic w_starved;
    logic w_d_gnt;
    logic w_i_gnt;
    logic w_read;
    logic w_d_rvalid;
    logic w_i_rvalid;

    assign w_starved = (r_wait_cnt == c_CNT_MAX);

    // The instruction port wins only when the data port is idle or when it
    // has been starved long enough; nothing is granted while in reset.
    assign w_i_gnt = !rst && bus.i_req && (!bus.d_req || w_starved);
    assign w_d_gnt = !rst && bus.d_req && !w_i_gnt;

    // Instruction grants are always reads; data grants are reads only with
    // no byte enable set.
    assign w_read = w_i_gnt || (w_d_gnt && (bus.d_wea == '0));

    // Return-path valids are gated by rst so a read granted just before reset
    // never shows up while reset is asserted.
    assign w_d_rvalid = !rst && r_tag_valid && !r_tag_port;
    assign w_i_rvalid = !rst && r_tag_valid &&  r_tag_port;

    // Grant and SRAM drive
    assign bus.d_gnt      = w_d_gnt;
    assign bus.i_gnt      = w_i_gnt;
    assign bus.sram_ena   = w_d_gnt || w_i_gnt;
    assign bus.sram_addra = w_i_gnt ? bus.i_addr : bus.d_addr;
    assign bus.sram_wea   = w_d_gnt ? bus.d_wea : {c_BE_W{1'b0}};
    assign bus.sram_dina  = bus.d_dina;

    // Read return: pass SRAM data through in the valid cycle, otherwise
    // present the last value this port received.
    assign bus.d_rvalid = w_d_rvalid;
    assign bus.i_rvalid = w_i_rvalid;
    assign bus.d_rdata  = rst ? {LEN_DATA{1'b0}} :
                          (w_d_rvalid ? bus.sram_douta : r_d_hold);
    assign bus.i_rdata  = rst ? {LEN_DATA{1'b0}} :
                          (w_i_rvalid ? bus.sram_douta : r_i_hold);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt  <= '0;
            r_tag_valid <= 1'b0;
            r_tag_port  <= 1'b0;
            r_d_hold    <= '0;
            r_i_hold    <= '0;
        end else begin
            // Count consecutive denied instruction cycles, saturating
            if (bus.i_req && !w_i_gnt) begin
                if (!w_starved) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end

            r_tag_valid <= w_read;
            r_tag_port  <= w_i_gnt;

            if (w_d_rvalid) begin
                r_d_hold <= bus.sram_douta;
            end
            if (w_i_rvalid) begin
                r_i_hold <= bus.sram_douta;
            end
        end
    end
endmodule
`default_nettype wire
